// File: rtl/cim_inst_queue_pkg.sv
// Shared types and field-position helpers for the CIM instruction queue.
// Word layout is {op, s1, s2, d1} with d1 in the least significant bits.
package cim_inst_queue_pkg;

  localparam int OP_WIDTH_DEF   = 5;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int NOP_OP         = 0;

  typedef enum logic [1:0] {
    FLD_D1 = 2'd0,
    FLD_S2 = 2'd1,
    FLD_S1 = 2'd2,
    FLD_OP = 2'd3
  } field_e;

  typedef struct packed {
    logic [OP_WIDTH_DEF-1:0]   op;
    logic [ADDR_WIDTH_DEF-1:0] s1;
    logic [ADDR_WIDTH_DEF-1:0] s2;
    logic [ADDR_WIDTH_DEF-1:0] d1;
  } cim_fields_t;

  // LSB position of a field; each address field occupies addr_w bits above the previous one.
  function automatic int field_lsb(input field_e f, input int addr_w);
    int pos;
    pos = 0;
    case (f)
      FLD_OP:  pos = 3 * addr_w;
      FLD_S1:  pos = 2 * addr_w;
      FLD_S2:  pos = addr_w;
      default: pos = 0;
    endcase
    return pos;
  endfunction

  function automatic int inst_width(input int op_w, input int addr_w);
    return op_w + 3 * addr_w;
  endfunction

endpackage

// File: rtl/cim_inst_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on head_o.
// Storage is cleared by reset so the head reads as zero until first written.
module cim_inst_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/cim_inst_queue.sv
// Instruction queue + decoder: drops NOPs and out-of-range words, buffers the rest.
// Define CIM_INST_QUEUE_BYPASS_EN to let a word pass straight through an empty queue.
module cim_inst_queue
  import cim_inst_queue_pkg::*;
#(
  parameter  int OP_WIDTH   = 5,
  parameter  int ADDR_WIDTH = 9,
  parameter  int CIM_DEPTH  = 512,
  parameter  int DEPTH      = 8,
  parameter  int NOP_OPCODE = NOP_OP,
  localparam int INST_WIDTH = inst_width(OP_WIDTH, ADDR_WIDTH),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_WIDTH-1:0]   out_op,
  output logic [ADDR_WIDTH-1:0] out_s1,
  output logic [ADDR_WIDTH-1:0] out_s2,
  output logic [ADDR_WIDTH-1:0] out_d1,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  err_addr,
  output logic [7:0]            err_cnt,
  input  logic                  err_clr
);

  localparam int OP_LSB = field_lsb(FLD_OP, ADDR_WIDTH);
  localparam int S1_LSB = field_lsb(FLD_S1, ADDR_WIDTH);
  localparam int S2_LSB = field_lsb(FLD_S2, ADDR_WIDTH);
  localparam int D1_LSB = field_lsb(FLD_D1, ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] ADDR_LIM = (ADDR_WIDTH + 1)'(CIM_DEPTH);

  logic [OP_WIDTH-1:0]   in_op;
  logic [ADDR_WIDTH-1:0] in_s1, in_s2, in_d1;
  logic                  push, addr_bad, is_nop, store_ok, bypass;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [INST_WIDTH-1:0] fifo_head, head_word;
  logic                  init_q;
  logic                  err_addr_q;
  logic [7:0]            err_cnt_q;

  assign in_op = in_inst[OP_LSB +: OP_WIDTH];
  assign in_s1 = in_inst[S1_LSB +: ADDR_WIDTH];
  assign in_s2 = in_inst[S2_LSB +: ADDR_WIDTH];
  assign in_d1 = in_inst[D1_LSB +: ADDR_WIDTH];

  assign in_ready = init_q & ~fifo_full;
  assign push     = in_valid & in_ready;
  assign addr_bad = ({1'b0, in_s1} >= ADDR_LIM) | ({1'b0, in_s2} >= ADDR_LIM)
                  | ({1'b0, in_d1} >= ADDR_LIM);
  assign is_nop   = (in_op == OP_WIDTH'(NOP_OPCODE));
  assign store_ok = push & ~addr_bad & ~is_nop;

`ifdef CIM_INST_QUEUE_BYPASS_EN
  assign bypass = store_ok & fifo_empty & out_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = store_ok & ~bypass;
  assign fifo_pop  = ~fifo_empty & out_ready;
  assign out_valid = ~fifo_empty | bypass;
  assign head_word = bypass ? in_inst : fifo_head;

  assign out_op = head_word[OP_LSB +: OP_WIDTH];
  assign out_s1 = head_word[S1_LSB +: ADDR_WIDTH];
  assign out_s2 = head_word[S2_LSB +: ADDR_WIDTH];
  assign out_d1 = head_word[D1_LSB +: ADDR_WIDTH];

  cim_inst_fifo #(
    .WIDTH (INST_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (in_inst),
    .head_o  (fifo_head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A push landing in a flush cycle is discarded entirely, so it is not counted as an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      err_addr_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      init_q <= 1'b1;
      if (err_clr) begin
        err_addr_q <= 1'b0;
        err_cnt_q  <= '0;
      end else if (push && addr_bad && !flush) begin
        err_addr_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_cim_inst_queue.sv
// Randomised bench for cim_inst_queue with a queue-based reference model and
// directed scenarios whose key results are pinned with literal expectations.
module tb_cim_inst_queue;

  localparam int LIM = 384;
  localparam int QD  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready, err_clr;
  logic [31:0] in_inst;
  logic        in_ready, out_valid, err_addr;
  logic [4:0]  out_op;
  logic [8:0]  out_s1, out_s2, out_d1;
  logic [3:0]  count;
  logic [7:0]  err_cnt;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mq[$];
  int          m_err_cnt;
  bit          m_err_addr;
  bit          started;
  bit          exp_valid, exp_byp;

  cim_inst_queue #(
    .OP_WIDTH   (5),
    .ADDR_WIDTH (9),
    .CIM_DEPTH  (LIM),
    .DEPTH      (QD),
    .NOP_OPCODE (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_s1    (out_s1),
    .out_s2    (out_s2),
    .out_d1    (out_d1),
    .count     (count),
    .err_addr  (err_addr),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int op, input int s1, input int s2, input int d1);
    return (32'(op) << 27) | (32'(s1) << 18) | (32'(s2) << 9) | 32'(d1);
  endfunction

  function automatic bit word_bad(input logic [31:0] w);
    return ((w >> 18) & 32'h1FF) >= LIM || ((w >> 9) & 32'h1FF) >= LIM || (w & 32'h1FF) >= LIM;
  endfunction

  function automatic bit word_nop(input logic [31:0] w);
    return (w >> 27) == 0;
  endfunction

  function automatic int rnd_addr();
    return ($urandom_range(0, 99) < 93) ? int'($urandom_range(0, LIM - 1)) : int'($urandom_range(LIM, 511));
  endfunction

  function automatic logic [31:0] rnd_legal();
    return mk(int'($urandom_range(1, 31)), int'($urandom_range(0, LIM - 1)),
              int'($urandom_range(0, LIM - 1)), int'($urandom_range(0, LIM - 1)));
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model (called away from clock edges).
  task automatic check_cycle();
    logic [31:0] w;
    exp_byp = 1'b0;
`ifdef CIM_INST_QUEUE_BYPASS_EN
    exp_byp = rst_n && started && mq.size() == 0 && in_valid && out_ready && !flush
              && !word_bad(in_inst) && !word_nop(in_inst);
`endif
    exp_valid = (mq.size() > 0) || exp_byp;
    cmp("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      w = exp_byp ? in_inst : mq[0];
      cmp("out_word", {out_op, out_s1, out_s2, out_d1}, w);
    end
    cmp("count", 32'(count), 32'(mq.size()));
    cmp("err_addr", 32'(err_addr), 32'(m_err_addr));
    cmp("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
    if (started) cmp("in_ready", 32'(in_ready), 32'(mq.size() < QD));
  endtask

  task automatic model_update();
    bit push;
    if (!rst_n) return;
    push = in_valid && started && mq.size() < QD;
    if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (push) begin
        if (word_bad(in_inst)) begin
          if (!err_clr) begin
            m_err_addr = 1'b1;
            if (m_err_cnt < 255) m_err_cnt++;
          end
        end else if (!word_nop(in_inst) && !exp_byp) begin
          mq.push_back(in_inst);
        end
      end
    end
    if (err_clr) begin
      m_err_addr = 1'b0;
      m_err_cnt  = 0;
    end
    started = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_err_addr = 1'b0;
    m_err_cnt  = 0;
    started    = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    started = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_valid"}, 32'(out_valid), 32'd0);
    cmp({tag, "_fields"}, {out_op, out_s1, out_s2, out_d1}, 32'd0);
    cmp({tag, "_count"}, 32'(count), 32'd0);
    cmp({tag, "_err_addr"}, 32'(err_addr), 32'd0);
    cmp({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; in_inst = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    release_reset();
    cmp("ready_after_reset", 32'(in_ready), 32'd1);

    // Basic pass of 0x18140C07 = {op 3, s1 5, s2 6, d1 7}
    in_inst = 32'h18140C07; in_valid = 1'b1; out_ready = 1'b1;
`ifdef CIM_INST_QUEUE_BYPASS_EN
    #1;
    cmp("byp_valid", 32'(out_valid), 32'd1);
    cmp("byp_op", 32'(out_op), 32'd3);
    cmp("byp_count", 32'(count), 32'd0);
    step();
    idle();
    step();
`else
    step();
    idle();
    cmp("basic_valid", 32'(out_valid), 32'd1);
    cmp("basic_op", 32'(out_op), 32'd3);
    cmp("basic_s1", 32'(out_s1), 32'd5);
    cmp("basic_s2", 32'(out_s2), 32'd6);
    cmp("basic_d1", 32'(out_d1), 32'd7);
    step();
`endif
    cmp("basic_count", 32'(count), 32'd0);

    // Fill to full with backpressure, then drain in order across the pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_inst = rnd_legal(); in_valid = 1'b1;
      step();
      if (i == 7) begin
        cmp("fill_count", 32'(count), 32'd8);
        cmp("fill_ready", 32'(in_ready), 32'd0);
      end
    end
    idle(); out_ready = 1'b1;
    repeat (9) step();

    // Range check and saturating error count
    in_inst = mk(3, 400, 1, 2); in_valid = 1'b1;
    step();
    cmp("range_err_addr", 32'(err_addr), 32'd1);
    cmp("range_err_cnt", 32'(err_cnt), 32'd1);
    cmp("range_count", 32'(count), 32'd0);
    repeat (299) step();
    cmp("range_sat", 32'(err_cnt), 32'd255);
    idle(); err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    cmp("clr_err_addr", 32'(err_addr), 32'd0);
    cmp("clr_err_cnt", 32'(err_cnt), 32'd0);

    // NOP drop
    in_inst = mk(0, 10, 11, 12); in_valid = 1'b1;
    step();
    in_inst = mk(3, 20, 21, 22);
    step();
    idle();
    repeat (3) step();
    cmp("nop_err_addr", 32'(err_addr), 32'd0);

    // Steady-state simultaneous push/pop at occupancy 4
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_inst = rnd_legal(); in_valid = 1'b1;
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_inst = rnd_legal(); in_valid = 1'b1;
      step();
    end
    cmp("pushpop_count", 32'(count), 32'd4);
    idle();
    repeat (5) step();

    // Flush at occupancy 5
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_inst = rnd_legal(); in_valid = 1'b1;
      step();
    end
    idle();
    cmp("preflush_count", 32'(count), 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    cmp("flush_count", 32'(count), 32'd0);
    cmp("flush_valid", 32'(out_valid), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      flush     = ($urandom_range(0, 99) < 2);
      err_clr   = ($urandom_range(0, 99) < 3);
      in_valid  = !flush && ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_inst   = mk(int'($urandom_range(0, 4)), rnd_addr(), rnd_addr(), rnd_addr());
      step();
    end
    idle();

    // Asynchronous reset in the middle of traffic
    out_ready = 1'b0;
    in_inst = mk(2, 500, 0, 0); in_valid = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      in_inst = rnd_legal();
      step();
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    release_reset();
    for (int i = 0; i < 40; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      in_inst   = mk(int'($urandom_range(0, 4)), rnd_addr(), rnd_addr(), rnd_addr());
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
